regfile_debug_seq: RTL and testbench

Debug-port sequencer for the 32×32 register file. It takes host commands (single read, single write, clear-all, dump-all, release) and turns them into correctly phased SRAM strobes on the register file's debug port. It also owns the hold line that places the register file and core in debug mode. It sits between the host/loader link and the register file, and is the only driver of the debug port.

---
 rtl/regfile_dbg_pkg.sv | 26 ++
 rtl/regfile_debug_seq.sv | 155 +++++++++++++++
 tb/tb_regfile_debug_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dbg_pkg.sv
// Shared types for the register-file debug-port sequencer: host op codes,
// sequencer phases and the register count.
package regfile_dbg_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

   typedef enum logic [2:0] {
      OP_READ    = 3'b000,
      OP_WRITE   = 3'b001,
      OP_CLEAR   = 3'b010,
      OP_DUMP    = 3'b011,
      OP_RELEASE = 3'b100
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLDW,
      S_RSETUP,
      S_SAMPLE,
      S_RESP
   } state_e;

endpackage

// File: rtl/regfile_debug_seq.sv
// Debug-port sequencer: turns host read/write/clear/dump/release commands into
// phased strobes on the register file debug port and owns the debug hold line.
module regfile_debug_seq
   import regfile_dbg_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_last,
   output logic              hold,
   output logic              dbg_oe,
   output logic              dbg_we,
   output logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_wdata,
   input  logic [DATA_W-1:0] dbg_rdata
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   state_e            state, state_next;
   op_e               op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] sweep;
   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic              sweeping;
   logic              last_idx;
   logic              accept;

   // Sweeping ops walk the internal counter; single ops use the latched index.
   assign sweeping = (op_q == OP_CLEAR) || (op_q == OP_DUMP);
   assign cur_addr = sweeping ? sweep : addr_q;
   assign cur_data = (op_q == OP_CLEAR) ? '0 : data_q;
   assign last_idx = (sweep == LAST_IDX);
   assign accept   = cmd_valid && (state == S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Strobes are decoded from the state so a reset drops them without a clock.
   always_comb begin
      state_next = state;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      dbg_oe     = 1'b0;
      dbg_we     = 1'b0;
      dbg_addr   = '0;
      dbg_wdata  = '0;
      case (state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               case (cmd_op)
                  OP_READ, OP_DUMP:   state_next = S_RSETUP;
                  OP_WRITE, OP_CLEAR: state_next = S_SETUP;
                  default:            state_next = S_IDLE;
               endcase
            end
         end
         S_SETUP: begin
            dbg_addr   = cur_addr;
            dbg_wdata  = cur_data;
            state_next = S_STROBE;
         end
         S_STROBE: begin
            dbg_addr   = cur_addr;
            dbg_wdata  = cur_data;
            dbg_we     = 1'b1;
            state_next = S_HOLDW;
         end
         S_HOLDW: begin
            dbg_addr   = cur_addr;
            dbg_wdata  = cur_data;
            state_next = ((op_q == OP_CLEAR) && !last_idx) ? S_SETUP : S_IDLE;
         end
         S_RSETUP: begin
            dbg_addr   = cur_addr;
            dbg_oe     = 1'b1;
            state_next = S_SAMPLE;
         end
         S_SAMPLE: begin
            dbg_addr   = cur_addr;
            dbg_oe     = 1'b1;
            state_next = S_RESP;
         end
         S_RESP: begin
            // Address is held through the response so it only moves in RSETUP or IDLE.
            dbg_addr  = cur_addr;
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               state_next = ((op_q == OP_DUMP) && !last_idx) ? S_RSETUP : S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Command latch, hold line, sweep counter and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold     <= 1'b1;
         op_q     <= OP_READ;
         addr_q   <= '0;
         data_q   <= '0;
         sweep    <= '0;
         rsp_addr <= '0;
         rsp_data <= '0;
         rsp_last <= 1'b0;
      end else begin
         if (accept) begin
            if (cmd_op == OP_RELEASE) begin
               hold <= 1'b0;
            end else if (cmd_op <= 3'b011) begin
               hold   <= 1'b1;
               op_q   <= op_e'(cmd_op);
               addr_q <= cmd_addr;
               data_q <= cmd_data;
               sweep  <= '0;
            end
         end
         if ((state == S_HOLDW) && (op_q == OP_CLEAR)) begin
            sweep <= sweep + ADDR_W'(1);
         end
         if (state == S_SAMPLE) begin
            rsp_data <= dbg_rdata;
            rsp_addr <= cur_addr;
            rsp_last <= !sweeping || last_idx;
         end
         if ((state == S_RESP) && rsp_ready) begin
            rsp_last <= 1'b0;
            if (op_q == OP_DUMP) begin
               sweep <= sweep + ADDR_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_regfile_debug_seq.sv
// Self-checking bench for regfile_debug_seq: a behavioural register-file model
// and expected-hold tracking are compared against the debug port and responses.
module tb_regfile_debug_seq;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;

   localparam logic [2:0] C_READ    = 3'b000;
   localparam logic [2:0] C_WRITE   = 3'b001;
   localparam logic [2:0] C_CLEAR   = 3'b010;
   localparam logic [2:0] C_DUMP    = 3'b011;
   localparam logic [2:0] C_RELEASE = 3'b100;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [2:0]        cmd_op = '0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [DATA_W-1:0] cmd_data = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;
   logic              hold;
   logic              dbg_oe;
   logic              dbg_we;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_wdata;
   logic [DATA_W-1:0] dbg_rdata;

   logic [DATA_W-1:0] env_rf   [NREG] = '{default: '0};
   logic [DATA_W-1:0] model_rf [NREG] = '{default: '0};
   logic [ADDR_W+DATA_W-1:0] we_log [$];
   int checks   = 0;
   int failures = 0;
   int overlap  = 0;

   regfile_debug_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
      .rsp_data(rsp_data), .rsp_last(rsp_last),
      .hold(hold), .dbg_oe(dbg_oe), .dbg_we(dbg_we),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata)
   );

   always #5 clk = ~clk;

   // Stand-in register file on the debug port.
   assign dbg_rdata = env_rf[dbg_addr];
   always @(posedge clk) if (dbg_we) env_rf[dbg_addr] <= dbg_wdata;

   // Every write strobe is logged once, mid-cycle.
   always @(negedge clk) begin
      if (dbg_we) we_log.push_back({dbg_addr, dbg_wdata});
      if (dbg_we && dbg_oe) overlap++;
   end

   task automatic issue(input logic [2:0] op, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit ok;
      ok = 1'b0;
      cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (cmd_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("[TB] FAIL accept op=%0d: not accepted within 300 cycles, required acceptance", op);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks += 6;
      if (hold !== 1'b1)      begin failures++; $display("[TB] FAIL reset_hold got=%b want=1", hold); end
      if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
      if ({dbg_oe, dbg_we} !== 2'b00) begin failures++; $display("[TB] FAIL reset_strobes got=%b want=00", {dbg_oe, dbg_we}); end
      if (dbg_addr !== '0 || dbg_wdata !== '0) begin failures++; $display("[TB] FAIL reset_dbg got=%h/%h want=0/0", dbg_addr, dbg_wdata); end
      if (rsp_valid !== 1'b0 || rsp_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp got=%b%b want=00", rsp_valid, rsp_last); end
      if (rsp_addr !== '0 || rsp_data !== '0) begin failures++; $display("[TB] FAIL reset_rsp_data got=%h/%h want=0/0", rsp_addr, rsp_data); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read();
      int base;
      base = we_log.size();
      issue(C_WRITE, 5'd5, 32'hDEADBEEF);
      checks += 6;
      if (dbg_we !== 1'b0 || dbg_addr !== 5'd5 || dbg_wdata !== 32'hDEADBEEF) begin
         failures++; $display("[TB] FAIL wr_setup got we=%b a=%0d d=%h want we=0 a=5 d=deadbeef", dbg_we, dbg_addr, dbg_wdata); end
      @(posedge clk); #1;
      if (dbg_we !== 1'b1 || dbg_addr !== 5'd5) begin
         failures++; $display("[TB] FAIL wr_strobe got we=%b a=%0d want we=1 a=5", dbg_we, dbg_addr); end
      @(posedge clk); #1;
      if (dbg_we !== 1'b0 || dbg_addr !== 5'd5 || dbg_wdata !== 32'hDEADBEEF) begin
         failures++; $display("[TB] FAIL wr_holdw got we=%b a=%0d d=%h want we=0 a=5 d=deadbeef", dbg_we, dbg_addr, dbg_wdata); end
      if (cmd_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_busy got=%b want=0", cmd_ready); end
      @(posedge clk); #1;
      if (cmd_ready !== 1'b1 || dbg_addr !== '0) begin
         failures++; $display("[TB] FAIL wr_done got rdy=%b a=%0d want rdy=1 a=0", cmd_ready, dbg_addr); end
      if (we_log.size() != base + 1 || we_log[base] !== {5'd5, 32'hDEADBEEF}) begin
         failures++; $display("[TB] FAIL wr_pulses got n=%0d want n=1 at 5/deadbeef", we_log.size() - base); end
      model_rf[5] = 32'hDEADBEEF;

      issue(C_READ, 5'd5, '0);
      checks += 3;
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rd_early got=%b want=0", rsp_valid); end
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_addr !== 5'd5 || rsp_data !== model_rf[5] || rsp_last !== 1'b1) begin
         failures++; $display("[TB] FAIL rd_rsp got v=%b a=%0d d=%h l=%b want v=1 a=5 d=%h l=1",
                              rsp_valid, rsp_addr, rsp_data, rsp_last, model_rf[5]); end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL rd_done got v=%b rdy=%b want v=0 rdy=1", rsp_valid, cmd_ready); end
   endtask

   task automatic test_clear_all();
      int base, n, bad;
      issue(C_WRITE, 5'd31, 32'h1234);
      repeat (3) begin @(posedge clk); #1; end
      model_rf[31] = 32'h1234;
      base = we_log.size();
      issue(C_CLEAR, '0, 32'hFFFF_FFFF);
      n = 0;
      while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      checks += 4;
      if (n != 96) begin failures++; $display("[TB] FAIL clr_cycles got=%0d want=96", n); end
      bad = 0;
      if (we_log.size() == base + NREG) begin
         for (int i = 0; i < NREG; i++)
            if (we_log[base + i] !== {5'(i), 32'h0}) bad++;
      end
      if (we_log.size() != base + NREG || bad != 0) begin
         failures++; $display("[TB] FAIL clr_pulses got n=%0d bad=%0d want n=32 bad=0", we_log.size() - base, bad); end
      for (int i = 0; i < NREG; i++) model_rf[i] = '0;
      issue(C_READ, 5'd31, '0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_data !== model_rf[31]) begin
         failures++; $display("[TB] FAIL clr_read31 got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_data, model_rf[31]); end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (cmd_ready !== 1'b1) begin failures++; $display("[TB] FAIL clr_read_done got=%b want=1", cmd_ready); end
   endtask

   task automatic test_dump();
      int idx, iter;
      bit stalled;
      logic [ADDR_W-1:0] prev_a;
      logic [DATA_W-1:0] prev_d;
      for (int i = 0; i < NREG; i++) begin
         logic [DATA_W-1:0] d;
         d = $urandom;
         issue(C_WRITE, 5'(i), d);
         repeat (3) begin @(posedge clk); #1; end
         model_rf[i] = d;
      end
      issue(C_DUMP, '0, '0);
      idx = 0; iter = 0; stalled = 1'b0; prev_a = '0; prev_d = '0;
      while (idx < NREG && iter < 3000) begin
         @(negedge clk);
         iter++;
         rsp_ready = ($urandom_range(0, 2) == 0);
         if (rsp_valid) begin
            if (stalled) begin
               checks++;
               if (rsp_addr !== prev_a || rsp_data !== prev_d) begin
                  failures++; $display("[TB] FAIL dump_stable got %0d/%h want %0d/%h", rsp_addr, rsp_data, prev_a, prev_d); end
            end
            if (rsp_ready) begin
               checks++;
               if (rsp_addr !== 5'(idx) || rsp_data !== model_rf[idx] || rsp_last !== (idx == NREG - 1)) begin
                  failures++; $display("[TB] FAIL dump_rsp got a=%0d d=%h l=%b want a=%0d d=%h l=%b",
                                       rsp_addr, rsp_data, rsp_last, idx, model_rf[idx], (idx == NREG - 1)); end
               idx++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1; prev_a = rsp_addr; prev_d = rsp_data;
            end
         end
      end
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checks += 2;
      if (idx != NREG) begin failures++; $display("[TB] FAIL dump_count got=%0d want=32", idx); end
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL dump_done got rdy=%b v=%b want rdy=1 v=0", cmd_ready, rsp_valid); end
   endtask

   task automatic test_reset_mid_clear();
      int base, n, bad;
      issue(C_CLEAR, '0, '0);
      repeat (13) @(posedge clk);
      #2;
      checks += 5;
      if (dbg_we !== 1'b1) begin failures++; $display("[TB] FAIL mid_strobe got=%b want=1", dbg_we); end
      rst = 1'b1;
      #1;
      if (dbg_we !== 1'b0 || hold !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL mid_async got we=%b hold=%b v=%b want 0 1 0", dbg_we, hold, rsp_valid); end
      @(negedge clk);
      rst = 1'b0;
      base = we_log.size();
      repeat (5) begin @(posedge clk); #1; end
      if (we_log.size() != base || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         failures++; $display("[TB] FAIL mid_quiet got pulses=%0d v=%b rdy=%b want 0 0 1", we_log.size() - base, rsp_valid, cmd_ready); end
      issue(C_CLEAR, '0, '0);
      n = 0;
      while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
      if (n != 96) begin failures++; $display("[TB] FAIL mid_reclear_cycles got=%0d want=96", n); end
      bad = 0;
      if (we_log.size() == base + NREG) begin
         for (int i = 0; i < NREG; i++)
            if (we_log[base + i][DATA_W +: ADDR_W] !== 5'(i)) bad++;
      end
      if (we_log.size() != base + NREG || bad != 0) begin
         failures++; $display("[TB] FAIL mid_sweep_restart got n=%0d bad=%0d want n=32 bad=0", we_log.size() - base, bad); end
      for (int i = 0; i < NREG; i++) model_rf[i] = '0;
   endtask

   task automatic test_release_noop();
      int base, act;
      base = we_log.size();
      issue(C_RELEASE, '0, '0);
      checks += 4;
      if (hold !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL release got hold=%b rdy=%b v=%b want 0 1 0", hold, cmd_ready, rsp_valid); end
      issue(3'b110, 5'd9, 32'hCAFE);
      if (cmd_ready !== 1'b1 || hold !== 1'b0) begin
         failures++; $display("[TB] FAIL noop_accept got rdy=%b hold=%b want 1 0", cmd_ready, hold); end
      act = 0;
      repeat (4) begin
         if (dbg_oe || dbg_we || dbg_addr != '0 || dbg_wdata != '0 || rsp_valid) act++;
         @(posedge clk); #1;
      end
      if (act != 0 || we_log.size() != base) begin
         failures++; $display("[TB] FAIL noop_quiet got active=%0d pulses=%0d want 0 0", act, we_log.size() - base); end
      issue(C_WRITE, 5'd7, 32'h7777);
      if (hold !== 1'b1) begin failures++; $display("[TB] FAIL rehold got=%b want=1", hold); end
      repeat (3) begin @(posedge clk); #1; end
      model_rf[7] = 32'h7777;
   endtask

   task automatic test_random_rw();
      logic hold_exp;
      hold_exp = 1'b1;
      for (int k = 0; k < 40; k++) begin
         logic [2:0] op;
         logic [ADDR_W-1:0] a;
         logic [DATA_W-1:0] d;
         int sel;
         sel = $urandom_range(0, 9);
         op = (sel < 4) ? C_WRITE : (sel < 8) ? C_READ : (sel == 8) ? C_RELEASE : 3'($urandom_range(5, 7));
         a = 5'($urandom);
         d = $urandom;
         rsp_ready = $urandom_range(0, 1);
         issue(op, a, d);
         if (op == C_WRITE || op == C_READ) hold_exp = 1'b1;
         else if (op == C_RELEASE) hold_exp = 1'b0;
         checks++;
         if (hold !== hold_exp) begin failures++; $display("[TB] FAIL rnd_hold op=%0d got=%b want=%b", op, hold, hold_exp); end
         if (op == C_WRITE) begin
            repeat (3) begin @(posedge clk); #1; end
            model_rf[a] = d;
            rsp_ready = 1'b0;
         end else if (op == C_READ) begin
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_addr !== a || rsp_data !== model_rf[a] || rsp_last !== 1'b1) begin
               failures++; $display("[TB] FAIL rnd_read got v=%b a=%0d d=%h l=%b want v=1 a=%0d d=%h l=1",
                                    rsp_valid, rsp_addr, rsp_data, rsp_last, a, model_rf[a]); end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
         end else begin
            rsp_ready = 1'b0;
         end
      end
      checks++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL rnd_end got rdy=%b v=%b want 1 0", cmd_ready, rsp_valid); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_clear_all();
      test_dump();
      test_reset_mid_clear();
      test_release_noop();
      test_random_rw();
      checks++;
      if (overlap != 0) begin failures++; $display("[TB] FAIL oe_we_overlap got=%0d want=0", overlap); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
